store_debouncer: RTL and testbench

Input conditioner that sits directly upstream of `memory_system`. It synchronizes the raw store pushbutton and the data/address slide switches, debounces the button, and emits exactly one single-cycle `store` strobe per physical press. The strobe comes with registered `data`/`addr` values that stay stable until the next strobe, so the downstream byte memories latch clean, glitch-free values.

---
 rtl/store_pkg.sv | 20 ++
 rtl/sync2.sv | 23 ++
 rtl/store_debouncer.sv | 140 ++++++++++++++
 tb/tb_store_debouncer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the store input conditioner and memory_system:
// FSM state encoding and default widths/debounce length.
package store_pkg;

  // 10 ms of stable input at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  // Widths shared with memory_system
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    FIRE         = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/sync2.sv
// Parameterized-width two flip-flop synchronizer for asynchronous inputs.
// Deliberately not reset: a button held through reset must appear on the
// synchronized output as soon as the clock runs, so no false edge is seen.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  // stage 0 captures the raw input, stage 1 settles metastability
  always_ff @(posedge clk) begin
    meta_p0 <= d;
    sync_p1 <= meta_p0;
  end

  assign q = sync_p1;

endmodule

// File: rtl/store_debouncer.sv
// Store pushbutton conditioner: synchronizes button and switches, debounces
// the button and emits one single-cycle store strobe per press, together with
// registered data/addr that hold until the next strobe.
// Optional feature: define STORE_AUTO_INC_EN to drive addr from an internal
// wrapping write pointer instead of the address switches.
module store_debouncer
  import store_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_store,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [ADDR_W-1:0] sw_addr,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              store,
  output logic              busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              btn_s;
  logic [DATA_W-1:0] sw_data_s;
  logic [ADDR_W-1:0] sw_addr_s;

  logic              btn_prev;
  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              load;

  // ---- synchronizer stage boundary ----
  sync2 #(.WIDTH(1)) u_sync_btn (
    .clk (clk),
    .d   (btn_store),
    .q   (btn_s)
  );

  sync2 #(.WIDTH(DATA_W + ADDR_W)) u_sync_sw (
    .clk (clk),
    .d   ({sw_data, sw_addr}),
    .q   ({sw_data_s, sw_addr_s})
  );

  // next-state, counter and load decode; counter restarts on every transition
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (btn_s && !btn_prev) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_s)               state_next = IDLE;
        else if (cnt == CNT_LAST) state_next = FIRE;
      end
      FIRE: begin
        state_next = HELD;
      end
      HELD: begin
        if (!btn_s) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_s)                state_next = HELD;
        else if (cnt == CNT_LAST) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next != state)
      cnt_next = '0;
    else if ((state == PRESS_WAIT) || (state == RELEASE_WAIT))
      cnt_next = cnt + 1'b1;

    load = (state_next == FIRE);
  end

  // FSM state, debounce counter and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      btn_prev <= 1'b1;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      btn_prev <= btn_s;
    end
  end

  assign store = (state == FIRE);
  assign busy  = (state != IDLE);

  // ---- output register stage boundary ----
`ifdef STORE_AUTO_INC_EN
  logic [ADDR_W-1:0] wr_ptr;
  logic              sw_addr_unused;

  assign sw_addr_unused = ^sw_addr_s;

  // write pointer advances as FIRE is left, wrapping naturally at 2^ADDR_W
  always_ff @(posedge clk) begin
    if (reset)
      wr_ptr <= '0;
    else if (state == FIRE)
      wr_ptr <= wr_ptr + 1'b1;
  end

  // capture data and the pointer used for this strobe on entry to FIRE
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      addr <= '0;
    end else if (load) begin
      data <= sw_data_s;
      addr <= wr_ptr;
    end
  end
`else
  // capture switch values on entry to FIRE; hold them until the next strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      addr <= '0;
    end else if (load) begin
      data <= sw_data_s;
      addr <= sw_addr_s;
    end
  end
`endif

endmodule

// File: tb/tb_store_debouncer.sv
// Directed bench for store_debouncer with DEBOUNCE_CYCLES=4. Expected strobes
// (cycle, data, addr) are queued as presses are driven and matched against
// each observed strobe.
module tb_store_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_store;
  logic [7:0] sw_data;
  logic [1:0] sw_addr;
  logic [7:0] data;
  logic [1:0] addr;
  logic       store;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [1:0] a;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pushes = 0;
  int         strobes = 0;
  logic       prev_store = 1'b0;
  logic [1:0] ptr_exp = 2'd0;
  int         c;

  store_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .DATA_W          (8),
    .ADDR_W          (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_store (btn_store),
    .sw_data   (sw_data),
    .sw_addr   (sw_addr),
    .data      (data),
    .addr      (addr),
    .store     (store),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // strobe for a clean rise driven at cycle t: 2 sync cycles, then D+1
  task automatic push(input int t, input logic [7:0] d, input logic [1:0] a);
    exp_t e;
    e.cyc = t + 2 + D + 1;
    e.d   = d;
`ifdef STORE_AUTO_INC_EN
    e.a   = ptr_exp;
    ptr_exp = ptr_exp + 2'd1;
`else
    e.a   = a;
`endif
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic press(input logic [7:0] d, input logic [1:0] a, input int hold);
    tick();
    sw_data   = d;
    sw_addr   = a;
    btn_store = 1'b1;
    push(cyc, d, a);
    repeat (hold) tick();
    btn_store = 1'b0;
    repeat (12) tick();
  endtask

  // strobe monitor: width, timing and captured values against the queue
  always @(negedge clk) begin
    if (store) begin
      exp_t e;
      strobes++;
      check("store_width", {31'd0, prev_store}, 32'd0);
      check("store_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("store_cycle", cyc, e.cyc);
        check("store_data", {24'd0, data}, {24'd0, e.d});
        check("store_addr", {30'd0, addr}, {30'd0, e.a});
      end
    end
    prev_store = store;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    btn_store = 1'b0;
    sw_data   = 8'h00;
    sw_addr   = 2'b00;
    repeat (5) tick();
    @(negedge clk);
    check("reset_store", {31'd0, store}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_addr", {30'd0, addr}, 32'd0);
    tick();
    reset = 1'b0;
    ptr_exp = 2'd0;
    repeat (3) tick();

    // clean press with busy timing
    sw_data   = 8'hA5;
    sw_addr   = 2'b10;
    btn_store = 1'b1;
    c = cyc;
    push(c, 8'hA5, 2'b10);
    wait_cyc(c + 2);
    check("busy_before_edge", {31'd0, busy}, 32'd0);
    wait_cyc(c + 3);
    check("busy_after_edge", {31'd0, busy}, 32'd1);
    while (cyc < c + 20) tick();

    // switch change while HELD must not reach the outputs
    sw_data = 8'h3C;
    sw_addr = 2'b01;
    repeat (3) tick();
    @(negedge clk);
    check("held_data", {24'd0, data}, 32'h0000_00A5);
    check("held_busy", {31'd0, busy}, 32'd1);

    // release with 2-cycle high glitches
    tick();
    btn_store = 1'b0; tick();
    btn_store = 1'b1; tick(); tick();
    btn_store = 1'b0; tick();
    btn_store = 1'b1; tick(); tick();
    btn_store = 1'b0;
    c = cyc;
    wait_cyc(c + 6);
    check("release_busy_hold", {31'd0, busy}, 32'd1);
    wait_cyc(c + 7);
    check("release_busy_fall", {31'd0, busy}, 32'd0);
    check("release_data", {24'd0, data}, 32'h0000_00A5);
    repeat (4) tick();

    // bouncy press: 1,0,1,0 then steady high
    sw_data = 8'h5A;
    sw_addr = 2'b01;
    btn_store = 1'b1; tick();
    btn_store = 1'b0; tick();
    btn_store = 1'b1; tick();
    btn_store = 1'b0; tick();
    btn_store = 1'b1;
    push(cyc, 8'h5A, 2'b01);
    repeat (10) tick();
    btn_store = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("bouncy_data", {24'd0, data}, 32'h0000_005A);
    check("bouncy_busy", {31'd0, busy}, 32'd0);

    // reset during PRESS_WAIT with the button held
    tick();
    sw_data   = 8'h77;
    sw_addr   = 2'b11;
    btn_store = 1'b1;
    c = cyc;
    while (cyc < c + 4) tick();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    ptr_exp = 2'd0;
    @(negedge clk);
    check("rst_mid_store", {31'd0, store}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_data", {24'd0, data}, 32'd0);
    check("rst_mid_addr", {30'd0, addr}, 32'd0);
    repeat (10) tick();
    @(negedge clk);
    check("held_thru_reset_busy", {31'd0, busy}, 32'd0);
    tick();
    btn_store = 1'b0;
    repeat (6) tick();
    press(8'hC3, 2'b00, 8);

    // five presses after a fresh reset
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    ptr_exp = 2'd0;
    repeat (3) tick();
    press(8'h11, 2'b11, 8);
    press(8'h22, 2'b10, 8);
    press(8'h33, 2'b01, 8);
    press(8'h44, 2'b00, 8);
    press(8'h55, 2'b11, 8);

    repeat (5) tick();
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("strobe_count", strobes, pushes);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
